// File: rtl/disparity_search_ctrl.sv
// Stereo disparity search sequencer: feeds row pairs to the SSD MAC,
// sums per-row results into a window cost and tracks the argmin.
module disparity_search_ctrl #(
  parameter int WIN_ROWS = 6,
  parameter int MAX_DISP = 64,
  parameter int ROW_W    = 20,
  parameter int DISP_W   = $clog2(MAX_DISP),
  parameter int COST_W   = ROW_W + $clog2(WIN_ROWS)
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic                        start_in,
  output logic                        busy_out,
  output logic                        fetch_req_out,
  output logic [$clog2(WIN_ROWS)-1:0] fetch_row_out,
  output logic [DISP_W-1:0]           fetch_disp_out,
  input  logic                        fetch_valid_in,
  input  logic [47:0]                 fetch_left_in,
  input  logic [47:0]                 fetch_right_in,
  output logic                        mac_valid_out,
  output logic [47:0]                 mac_left_out,
  output logic [47:0]                 mac_right_out,
  input  logic [ROW_W-1:0]            mac_result_in,
  output logic                        done_out,
  output logic [DISP_W-1:0]           best_disp_out,
  output logic [COST_W-1:0]           best_cost_out
);

  localparam int RW = $clog2(WIN_ROWS);
  localparam logic [RW-1:0]     LAST_ROW  = RW'(WIN_ROWS - 1);
  localparam logic [DISP_W-1:0] LAST_DISP = DISP_W'(MAX_DISP - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
    S_COMPARE,
    S_DONE
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [RW-1:0]       r_row;
  logic [DISP_W-1:0]   r_disp;
  logic [COST_W-1:0]   r_cost;
  logic [COST_W-1:0]   r_min;
  logic [DISP_W-1:0]   r_arg;
  logic                r_pend;
  logic [DISP_W-1:0]   r_best_disp;
  logic [COST_W-1:0]   r_best_cost;

  logic                w_mac_valid;
  logic                w_lt;
  logic [COST_W-1:0]   w_acc;
  logic [COST_W-1:0]   w_min_n;
  logic [DISP_W-1:0]   w_arg_n;

  assign w_mac_valid    = (r_state == S_FETCH) & fetch_valid_in;
  assign mac_valid_out  = w_mac_valid;
  assign mac_left_out   = fetch_left_in;
  assign mac_right_out  = fetch_right_in;
  assign fetch_req_out  = (r_state == S_FETCH);
  assign fetch_row_out  = r_row;
  assign fetch_disp_out = r_disp;
  assign busy_out       = (r_state == S_FETCH) |
                          (r_state == S_DRAIN) |
                          (r_state == S_COMPARE);
  assign done_out       = (r_state == S_DONE);
  assign best_disp_out  = r_best_disp;
  assign best_cost_out  = r_best_cost;

  // Strict compare: ties keep the earlier (lower) disparity.
  assign w_acc   = r_pend ? r_cost + COST_W'(mac_result_in) : r_cost;
  assign w_lt    = r_cost < r_min;
  assign w_min_n = w_lt ? r_cost : r_min;
  assign w_arg_n = w_lt ? r_disp : r_arg;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:    if (start_in) w_next = S_FETCH;
      S_FETCH:   if (fetch_valid_in && r_row == LAST_ROW)
                   w_next = S_DRAIN;
      S_DRAIN:   w_next = S_COMPARE;
      S_COMPARE: w_next = (r_disp == LAST_DISP) ? S_DONE : S_FETCH;
      S_DONE:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state     <= S_IDLE;
      r_row       <= '0;
      r_disp      <= '0;
      r_cost      <= '0;
      r_min       <= '1;
      r_arg       <= '0;
      r_pend      <= 1'b0;
      r_best_disp <= '0;
      r_best_cost <= '0;
    end else begin
      r_state <= w_next;
      r_pend  <= w_mac_valid;
      unique case (r_state)
        S_IDLE: begin
          if (start_in) begin
            r_disp <= '0;
            r_row  <= '0;
            r_cost <= '0;
            r_min  <= '1;
            r_arg  <= '0;
          end
        end
        S_FETCH: begin
          r_cost <= w_acc;
          if (fetch_valid_in)
            r_row <= (r_row == LAST_ROW) ? '0 : r_row + RW'(1);
        end
        S_DRAIN: r_cost <= w_acc;
        S_COMPARE: begin
          r_min  <= w_min_n;
          r_arg  <= w_arg_n;
          r_cost <= '0;
          // Results are published so they are valid during DONE.
          if (r_disp == LAST_DISP) begin
            r_best_disp <= w_arg_n;
            r_best_cost <= w_min_n;
          end else begin
            r_disp <= r_disp + DISP_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_disparity_search_ctrl.sv
// Directed bench for disparity_search_ctrl with a behavioural SSD MAC
// and a fetch responder that can stall each request.
module tb_disparity_search_ctrl;

  localparam int DISP_W = 6;
  localparam int COST_W = 23;

  logic              clk_in = 1'b0;
  logic              rst_in = 1'b0;
  logic              start_in = 1'b0;
  logic              busy_out;
  logic              fetch_req_out;
  logic [2:0]        fetch_row_out;
  logic [DISP_W-1:0] fetch_disp_out;
  logic              fetch_valid_in = 1'b0;
  logic [47:0]       fetch_left_in = '0;
  logic [47:0]       fetch_right_in = '0;
  logic              mac_valid_out;
  logic [47:0]       mac_left_out;
  logic [47:0]       mac_right_out;
  logic [19:0]       mac_result_in = '0;
  logic              done_out;
  logic [DISP_W-1:0] best_disp_out;
  logic [COST_W-1:0] best_cost_out;

  disparity_search_ctrl dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .start_in       (start_in),
    .busy_out       (busy_out),
    .fetch_req_out  (fetch_req_out),
    .fetch_row_out  (fetch_row_out),
    .fetch_disp_out (fetch_disp_out),
    .fetch_valid_in (fetch_valid_in),
    .fetch_left_in  (fetch_left_in),
    .fetch_right_in (fetch_right_in),
    .mac_valid_out  (mac_valid_out),
    .mac_left_out   (mac_left_out),
    .mac_right_out  (mac_right_out),
    .mac_result_in  (mac_result_in),
    .done_out       (done_out),
    .best_disp_out  (best_disp_out),
    .best_cost_out  (best_cost_out)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  int         gap = 0;
  int         scnt = 0;
  int         match_disp = -1;
  logic [7:0] left_b = 8'h00;
  logic [7:0] match_b = 8'h00;
  logic [7:0] other_b = 8'h00;

  always @(negedge clk_in) begin
    fetch_left_in  = {6{left_b}};
    fetch_right_in = (int'(fetch_disp_out) == match_disp) ?
                     {6{match_b}} : {6{other_b}};
    if (gap == 0) begin
      fetch_valid_in = 1'b1;
    end else if (!fetch_req_out) begin
      fetch_valid_in = 1'b0;
      scnt = 0;
    end else if (scnt == gap) begin
      fetch_valid_in = 1'b1;
      scnt = 0;
    end else begin
      fetch_valid_in = 1'b0;
      scnt++;
    end
  end

  function automatic logic [19:0] ssd(input logic [47:0] l,
                                      input logic [47:0] r);
    int s;
    int d;
    s = 0;
    for (int i = 0; i < 6; i++) begin
      d = int'(l[8*i +: 8]) - int'(r[8*i +: 8]);
      s += d * d;
    end
    return 20'(s);
  endfunction

  always @(posedge clk_in)
    if (mac_valid_out)
      mac_result_in <= ssd(mac_left_out, mac_right_out);

  int cyc = 0;
  int mac_cnt = 0;
  int done_cnt = 0;

  always @(posedge clk_in) begin
    cyc++;
    if (mac_valid_out) mac_cnt++;
    if (done_out) done_cnt++;
  end

  task automatic run_search(input string tag,
                            input int exp_disp,
                            input int exp_cost,
                            input int exp_cyc,
                            input int exp_macs,
                            input bit poke);
    int s;
    int m0;
    int d0;
    bit seen;
    seen = 1'b0;
    m0 = mac_cnt;
    d0 = done_cnt;
    @(negedge clk_in);
    start_in = 1'b1;
    @(posedge clk_in);
    #1 start_in = 1'b0;
    s = cyc;
    chk({tag, "_busy_start"}, busy_out, 1);
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk_in);
      if (poke && i == 100) begin
        start_in = 1'b1;
        @(negedge clk_in);
        start_in = 1'b0;
        chk({tag, "_busy_poke"}, busy_out, 1);
      end
      if (done_out) begin
        seen = 1'b1;
        break;
      end
    end
    chk({tag, "_done_seen"}, seen, 1);
    chk({tag, "_done_cycle"}, cyc - s + 1, exp_cyc);
    chk({tag, "_best_disp"}, best_disp_out, exp_disp);
    chk({tag, "_best_cost"}, best_cost_out, exp_cost);
    chk({tag, "_busy_done"}, busy_out, 0);
    chk({tag, "_mac_pulses"}, mac_cnt - m0, exp_macs);
    if (poke) start_in = 1'b1;
    @(negedge clk_in);
    start_in = 1'b0;
    chk({tag, "_done_1cyc"}, done_out, 0);
    chk({tag, "_idle_after"}, busy_out, 0);
    chk({tag, "_done_count"}, done_cnt - d0, 1);
  endtask

  initial begin
    bit hit;
    int d0;
    repeat (3) @(negedge clk_in);
    chk("rst_busy", busy_out, 0);
    chk("rst_req", fetch_req_out, 0);
    chk("rst_mac_valid", mac_valid_out, 0);
    chk("rst_done", done_out, 0);
    chk("rst_best_disp", best_disp_out, 0);
    chk("rst_best_cost", best_cost_out, 0);
    chk("rst_row", fetch_row_out, 0);
    chk("rst_disp", fetch_disp_out, 0);
    rst_in = 1'b1;
    repeat (2) @(negedge clk_in);

    left_b = 8'h10; match_b = 8'h10; other_b = 8'h20;
    match_disp = 5; gap = 0;
    run_search("s1_match5", 5, 0, 513, 384, 1'b0);

    match_disp = -1;
    run_search("s1_nomatch", 0, 9216, 513, 384, 1'b0);

    left_b = 8'h00; other_b = 8'h01;
    run_search("s2_tie", 0, 36, 513, 384, 1'b0);

    left_b = 8'hFF; other_b = 8'h00;
    run_search("s3_worst", 0, 2340900, 513, 384, 1'b0);

    left_b = 8'h10; match_b = 8'h10; other_b = 8'h20;
    match_disp = 5; gap = 2;
    run_search("s4_stall", 5, 0, 1281, 384, 1'b0);

    gap = 0;
    run_search("s5_poke", 5, 0, 513, 384, 1'b1);

    hit = 1'b0;
    @(negedge clk_in);
    start_in = 1'b1;
    @(negedge clk_in);
    start_in = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk_in);
      if (fetch_disp_out == 6'd20) begin
        hit = 1'b1;
        break;
      end
    end
    chk("s6_reach_disp20", hit, 1);
    d0 = done_cnt;
    rst_in = 1'b0;
    #1;
    chk("s6_busy", busy_out, 0);
    chk("s6_req", fetch_req_out, 0);
    chk("s6_mac_valid", mac_valid_out, 0);
    chk("s6_done", done_out, 0);
    chk("s6_best_disp", best_disp_out, 0);
    chk("s6_best_cost", best_cost_out, 0);
    chk("s6_disp", fetch_disp_out, 0);
    @(negedge clk_in);
    rst_in = 1'b1;
    repeat (20) @(negedge clk_in);
    chk("s6_stay_idle", busy_out, 0);
    chk("s6_no_done", done_cnt - d0, 0);
    run_search("s6_restart", 5, 0, 513, 384, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/disparity_search_ctrl.md
Name: disparity_search_ctrl

Overview:
Sequences the 48-bit SSD MAC engine across a stereo disparity search for one output pixel. For each candidate disparity it fetches WIN_ROWS left/right 6-pixel row pairs from the line-buffer fetch port and forwards them to the MAC engine. It sums the per-row results into a window cost and keeps the minimum-cost disparity. It sits between the line-buffer reader and mac_engine_48bit, and reports the best disparity to the depth-map writer.

Parameters:
WIN_ROWS, 6, rows per matching window (>=2)
MAX_DISP, 64, number of disparities searched, 0..MAX_DISP-1 (>=2)
ROW_W, 20, width of the MAC engine result ($clog2(255*255*6)+1)
DISP_W, $clog2(MAX_DISP), disparity index width
COST_W, ROW_W+$clog2(WIN_ROWS), window cost width

Ports:
clk_in  input  1  system clock
rst_in  input  1  asynchronous, active-low reset
start_in  input  1  begin a search; sampled only in IDLE
busy_out  output  1  high from the cycle after an accepted start until done
fetch_req_out  output  1  request row pair (fetch_row_out, fetch_disp_out)
fetch_row_out  output  $clog2(WIN_ROWS)  window row index
fetch_disp_out  output  DISP_W  disparity being fetched
fetch_valid_in  input  1  row pair returned; counts only while fetch_req_out=1
fetch_left_in  input  48  left-image 6-pixel row
fetch_right_in  input  48  right-image 6-pixel row shifted by disparity
mac_valid_out  output  1  to MAC valid_in
mac_left_out  output  48  to MAC left_row
mac_right_out  output  48  to MAC right_row
mac_result_in  input  ROW_W  MAC accumulator (row SSD, registered, valid 1 cycle after mac_valid_out)
done_out  output  1  1-cycle pulse; results valid
best_disp_out  output  DISP_W  argmin disparity
best_cost_out  output  COST_W  minimum window cost

Behaviour:
- Reset (rst_in=0, async): state IDLE. All outputs 0 (busy, fetch_req, mac_valid, done, best_disp, best_cost, row/disp indices). Internal window cost and pending flag are cleared.
- States: IDLE, FETCH, DRAIN, COMPARE, DONE.
- IDLE: start_in=1 -> FETCH; disp=0, row=0, window_cost=0, running min=all-ones. best_*_out keep old values until DONE.
- FETCH: fetch_req_out=1 with the current row/disp. A handshake completes on any cycle with fetch_valid_in=1; the request stays held until it does, with no timeout.
  - On handshake: row++. At row==WIN_ROWS-1 go to DRAIN and reset row to 0.
  - fetch_valid_in while fetch_req_out=0 is ignored.
- mac_valid_out = (state==FETCH) & fetch_valid_in, combinational. mac_left_out and mac_right_out pass the fetch data through.
- Pending flag is registered from mac_valid_out. When set, window_cost += mac_result_in, unsigned, zero-extended to COST_W; cannot overflow.
- DRAIN: one cycle, fetch_req_out=0, absorbs the last row result. Always -> COMPARE.
- COMPARE: if window_cost < running min (strict), update min and argmin to disp. Ties keep the lower disparity.
  - Then clear window_cost.
  - If disp==MAX_DISP-1 -> DONE; else disp++ and -> FETCH.
- DONE: one cycle. done_out=1, best_disp_out/best_cost_out load the min/argmin, busy_out=0 in this cycle. Always -> IDLE.
- busy_out=1 in FETCH, DRAIN and COMPARE.
- start_in outside IDLE is ignored. start_in in the DONE cycle is ignored; it is accepted from IDLE the following cycle.
- Latency with fetch_valid_in held high: start at edge 0, FETCH from cycle 1.
  - Each disparity takes WIN_ROWS+2 cycles.
  - done_out is in cycle MAX_DISP*(WIN_ROWS+2)+1 (default: cycle 513).
  - Each stall cycle adds one cycle.
- Reset mid-search aborts immediately. No done_out is produced; outputs return to reset values.

Test Plan:
- Left rows all 0x10. Right rows 0x10 at disp 5, 0x20 elsewhere; valid held high -> done_out at cycle 513, best_disp_out=5, best_cost_out=0. Every other disparity's window cost is 9216.
- All rows identical cost at every disparity (left 0x00, right 0x01) -> best_disp_out=0, best_cost_out=36 (tie keeps lowest).
- Worst case: left 0xFF, right 0x00 everywhere -> best_cost_out=2,340,900 with no wrap; best_disp_out=0.
- Repeat scenario 1 with fetch_valid_in high every third cycle -> identical results. mac_valid_out pulses exactly 384 times; done_out is later by 2*384 cycles.
- start_in pulsed mid-search and again in the DONE cycle -> ignored; busy_out stays high, exactly one done_out per accepted start.
- rst_in low for 1 cycle during disp 20 -> all outputs 0 asynchronously, state IDLE, no done_out. A new start then completes normally with correct results.
